// File: rtl/word_uart_tx_if.sv
// rtl/word_uart_tx_if.sv - word handshake bundle for word_uart_tx
interface word_uart_tx_if;
   logic [31:0] i_word;
   logic        i_valid;
   logic        o_ready;

   modport master (output i_word, output i_valid, input o_ready);
   modport slave  (input i_word, input i_valid, output o_ready);
endinterface

// File: rtl/word_uart_tx.sv
// rtl/word_uart_tx.sv - serialises 32-bit words as four 8N1 UART bytes, LSB byte first
module word_uart_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   word_uart_tx_if.slave          bus,
   output logic                   o_Tx_Serial,
   output logic                   o_busy,
   output logic                   o_word_done,
   output logic [COUNT_WIDTH-1:0] o_words_sent
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [1:0]             byte_q, byte_d;
   logic [31:0]            shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   bit_end;

   assign bit_end = (cnt_q == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   // tx_d always carries the level of the bit that starts next cycle, keeping the line registered
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            cnt_d  = '0;
            bit_d  = '0;
            byte_d = '0;
            if (bus.i_valid) begin
               shift_d = bus.i_word;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[31:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (byte_q != 2'd3) begin
                  byte_d  = byte_q + 1'b1;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  byte_d  = '0;
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  done_d  = 1'b1;
                  count_d = count_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_ready  = (state_q == IDLE);
   assign o_busy       = (state_q != IDLE);
   assign o_Tx_Serial  = tx_q;
   assign o_word_done  = done_q;
   assign o_words_sent = count_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// tb/tb_word_uart_tx.sv - directed self-checking bench for word_uart_tx
module tb_word_uart_tx;
   localparam int CPB_A = 87;
   localparam int WORD_CYC = 40 * CPB_A;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   word_uart_tx_if bus_a ();
   word_uart_tx_if bus_b ();

   logic        tx_a, busy_a, done_a;
   logic [15:0] sent_a;
   logic        tx_b, busy_b, done_b;
   logic [1:0]  sent_b;

   word_uart_tx #(.CLKS_PER_BIT(CPB_A), .COUNT_WIDTH(16)) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a.slave), .o_Tx_Serial(tx_a),
      .o_busy(busy_a), .o_word_done(done_a), .o_words_sent(sent_a));

   word_uart_tx #(.CLKS_PER_BIT(4), .COUNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b.slave), .o_Tx_Serial(tx_b),
      .o_busy(busy_b), .o_word_done(done_b), .o_words_sent(sent_b));

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   logic line_s [0:WORD_CYC-1];

   always @(negedge clk) if (done_a === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Call #1 after the accept edge; returns #1 after the completion edge.
   task automatic capture_word(input logic [31:0] w, input logic [15:0] exp_cnt);
      int busy_cycles;
      int d0;
      int base;
      logic [7:0] got;
      logic exp_bit;
      logic frame_ok, width_ok;
      busy_cycles = 0;
      d0 = done_cnt;
      for (int c = 0; c < WORD_CYC; c++) begin
         line_s[c] = tx_a;
         if (busy_a === 1'b1) busy_cycles++;
         @(posedge clk); #1;
      end
      check("busy_cycles", busy_cycles, WORD_CYC);
      for (int b = 0; b < 4; b++) begin
         got = '0;
         frame_ok = 1'b1;
         width_ok = 1'b1;
         for (int f = 0; f < 10; f++) begin
            base = (b * 10 + f) * CPB_A;
            if (f == 0)      exp_bit = 1'b0;
            else if (f == 9) exp_bit = 1'b1;
            else             exp_bit = w[b * 8 + f - 1];
            if (f >= 1 && f <= 8) got[f-1] = line_s[base + CPB_A / 2];
            else if (line_s[base + CPB_A / 2] !== exp_bit) frame_ok = 1'b0;
            for (int k = 0; k < CPB_A; k++)
               if (line_s[base + k] !== exp_bit) width_ok = 1'b0;
         end
         check($sformatf("byte%0d", b), {24'd0, got}, {24'd0, w[b*8 +: 8]});
         check($sformatf("byte%0d_framing", b), {31'd0, frame_ok}, 32'd1);
         check($sformatf("byte%0d_bit_width", b), {31'd0, width_ok}, 32'd1);
      end
      check("done_pulse", {31'd0, done_a}, 32'd1);
      check("no_early_done", done_cnt, d0);
      check("ready_after_word", {31'd0, bus_a.o_ready}, 32'd1);
      check("busy_after_word", {31'd0, busy_a}, 32'd0);
      check("words_sent", {16'd0, sent_a}, {16'd0, exp_cnt});
   endtask

   task automatic send_single(input logic [31:0] w, input logic [15:0] exp_cnt);
      @(negedge clk);
      bus_a.i_word  = w;
      bus_a.i_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.i_valid = 1'b0;
      check("ready_drops", {31'd0, bus_a.o_ready}, 32'd0);
      capture_word(w, exp_cnt);
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, done_a}, 32'd0);
   endtask

   initial begin
      logic idle_ok;
      int   snap;
      int   waited;
      logic [1:0] exp_b;
      bus_a.i_word = '0; bus_a.i_valid = 1'b0;
      bus_b.i_word = '0; bus_b.i_valid = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", {31'd0, tx_a}, 32'd1);
      check("rst_ready", {31'd0, bus_a.o_ready}, 32'd1);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
      check("rst_words_sent", {16'd0, sent_a}, 32'd0);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;

      idle_ok = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (tx_a !== 1'b1 || bus_a.o_ready !== 1'b1 || sent_a !== 16'd0) idle_ok = 1'b0;
      end
      check("idle_1000", {31'd0, idle_ok}, 32'd1);

      send_single(32'h12345678, 16'd1);
      send_single(32'hDEADBEEF, 16'd2);
      send_single(32'h00000001, 16'd3);

      // back-to-back with i_valid held high
      @(negedge clk);
      bus_a.i_word  = 32'hA5A5A5A5;
      bus_a.i_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.i_word  = 32'h5A5A5A5A;
      capture_word(32'hA5A5A5A5, 16'd4);
      check("b2b_gap_high", {31'd0, tx_a}, 32'd1);
      @(posedge clk); #1;
      bus_a.i_valid = 1'b0;
      check("b2b_start_low", {31'd0, tx_a}, 32'd0);
      capture_word(32'h5A5A5A5A, 16'd5);

      // reset during bit 3 of byte 2 (frame bit 24)
      @(negedge clk);
      bus_a.i_word  = 32'hFFFFFFFF;
      bus_a.i_valid = 1'b1;
      @(posedge clk); #1;
      bus_a.i_valid = 1'b0;
      snap = done_cnt;
      repeat (24 * CPB_A + 40) @(posedge clk);
      #1;
      check("mid_frame_busy", {31'd0, busy_a}, 32'd1);
      @(negedge clk); rst_a = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_tx", {31'd0, tx_a}, 32'd1);
      check("rst_mid_ready", {31'd0, bus_a.o_ready}, 32'd1);
      check("rst_mid_words_sent", {16'd0, sent_a}, 32'd0);
      @(negedge clk); rst_a = 1'b0;
      repeat (WORD_CYC + 100) @(posedge clk);
      #1;
      check("rst_mid_no_done", done_cnt, snap);
      check("rst_mid_count_after", {16'd0, sent_a}, 32'd0);
      check("rst_mid_line_idle", {31'd0, tx_a}, 32'd1);

      // 2-bit counter wrap on the fast instance
      exp_b = 2'd0;
      for (int n = 0; n < 5; n++) begin
         exp_b = exp_b + 2'd1;
         @(negedge clk);
         bus_b.i_word  = 32'h0;
         bus_b.i_valid = 1'b1;
         @(posedge clk); #1;
         bus_b.i_valid = 1'b0;
         waited = 0;
         while (done_b !== 1'b1 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
         end
         check($sformatf("wrap_done_seen%0d", n), {31'd0, done_b}, 32'd1);
         check($sformatf("wrap_words_sent%0d", n), {30'd0, sent_b}, {30'd0, exp_b});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/word_uart_tx.md
Name: word_uart_tx

Overview:
Transmit-side counterpart of the instruction programmer's UART receive path. Accepts 32-bit words over a valid/ready handshake and serialises each word as four 8N1 UART bytes, least-significant byte first. The byte order matches the programmer's byte-assembly order, so words sent by this block are reassembled unchanged by the programmer. Used for instruction/memory readback to the host PC at the same bit rate as the receiver.

Parameters:
CLKS_PER_BIT, 87, clk cycles per UART bit; legal range 2..65535.
COUNT_WIDTH, 16, width of the words_sent counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
i_word  input  32  word to transmit; sampled only on an accept cycle.
i_valid  input  1  i_word is valid.
o_ready  output  1  block can accept a word; high only in IDLE.
o_Tx_Serial  output  1  UART line; idle high.
o_busy  output  1  high while any bit of a word is on the line.
o_word_done  output  1  one-cycle pulse when the 4th stop bit completes.
o_words_sent  output  COUNT_WIDTH  count of completed words.

Behaviour:
- Reset values at the edge where rst=1: o_Tx_Serial=1, o_ready=1, o_busy=0, o_word_done=0, o_words_sent=0, state=IDLE, byte index=0, bit index=0, clock count=0.
- rst mid-frame: the line returns high on the next cycle and the word is abandoned (no done pulse, no count). rst has priority over everything.
- Accept rule: i_valid && o_ready at a rising edge.
  - i_word is latched into a 32-bit shift register.
  - o_ready drops and o_busy rises.
  - o_Tx_Serial goes low starting the next cycle.
  - i_valid while not ready is ignored; no queueing.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept.
  - START: drive 0 for exactly CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive the LSB of the current byte. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then:
    - byte index < 3: increment byte index and go to START directly (no inter-byte idle gap).
    - byte index == 3: go to IDLE.
- Byte order on the line: i_word[7:0], [15:8], [23:16], [31:24]. Within each byte, bit 0 is sent first.
- Timing: every bit lasts exactly CLKS_PER_BIT cycles. One word occupies 40*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- Word completion: on the cycle after the last stop-bit cycle:
  - o_word_done=1 for that one cycle;
  - o_ready=1 and o_busy=0;
  - o_words_sent increments by 1, wrapping from 2^COUNT_WIDTH-1 to 0.
- Back-to-back: a word may be accepted in the same cycle o_word_done is high. Its start bit begins the next cycle, so the line stays high for exactly 1 cycle between words.
- The clock counter is sized for CLKS_PER_BIT-1 and resets to 0 at every bit boundary.
- o_Tx_Serial is registered, with no combinational path from inputs.

Test Plan:
- Reset then idle, no i_valid for 1000 cycles -> o_Tx_Serial=1, o_ready=1, o_words_sent=0 throughout.
- Send 0x12345678 (CLKS_PER_BIT=87), sampling mid-bit -> bytes 0x78, 0x56, 0x34, 0x12, each with start=0 and stop=1 and each bit 87 cycles wide. Total 3480 busy cycles. One o_word_done pulse; o_words_sent=1.
- Loopback through uart_rx into the programmer: send 0xDEADBEEF then 0x00000001 -> programmer instruction_data equals each word in order.
- Back-to-back: i_valid held high with 0xA5A5A5A5 then 0x5A5A5A5A -> second start bit begins exactly 1 cycle after the first word's final stop bit. o_words_sent=2.
- Assert rst during bit 3 of byte 2 of 0xFFFFFFFF -> o_Tx_Serial=1 the next cycle, no o_word_done pulse, o_words_sent=0, o_ready=1.
- COUNT_WIDTH=2, send 5 words of 0x00000000 -> o_words_sent sequence 1, 2, 3, 0, 1.
